// File: rtl/msk_rx_acq_ctrl.sv
// Acquisition/lock sequencer for the MSK receiver: timing settle, coarse CFO, fine track, sync search, lock.
// Optional macro MSK_ACQ_SYNC_TOL_EN enables Hamming-tolerant sync detection (SYNC_TOL bit errors).
module msk_rx_acq_ctrl #(
  parameter int                SYM_SETTLE   = 256,
  parameter int                CFO_TIMEOUT  = 4096,
  parameter int                TRK_SETTLE   = 512,
  parameter int                FW           = 32,
  parameter int                SYNC_W       = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = 32'hFFA50FFE,
  parameter int                SYNC_TOL     = 2,
  parameter int                SRCH_TIMEOUT = 8192,
  parameter int                FRAME_BITS   = 256,
  parameter int                MISS_MAX     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          sym_val_i,
  input  logic          coarse_done_i,
  input  logic [FW-1:0] coarse_freq_i,
  input  logic          data_i,
  input  logic          data_val_i,
  output logic          cfo_en_o,
  output logic          fine_en_o,
  output logic          freq_load_o,
  output logic [FW-1:0] freq_word_o,
  output logic          loop_rst_o,
  output logic          sync_hit_o,
  output logic          locked_o,
  output logic [2:0]    state_o,
  output logic [7:0]    retry_cnt_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TIM_ACQ = 3'd1;
  localparam logic [2:0] S_CFO_CRS = 3'd2;
  localparam logic [2:0] S_CFO_TRK = 3'd3;
  localparam logic [2:0] S_SRCH    = 3'd4;
  localparam logic [2:0] S_LOCKED  = 3'd5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(SYM_SETTLE, TRK_SETTLE), max2(CFO_TIMEOUT, SRCH_TIMEOUT)),
                                FRAME_BITS + SYNC_W);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int PW = $clog2(SYNC_W + 1);
`ifdef MSK_ACQ_SYNC_TOL_EN
  localparam int TOL_LIM = SYNC_TOL;
`else
  localparam int TOL_LIM = SYNC_TOL * 0;  // exact match only
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     miss_q, miss_d;
  // Only SYNC_W-1 history bits are stored; the newest bit completes the window combinationally.
  logic [SYNC_W-2:0] sr_q, sr_d;
  logic [FW-1:0]     freq_word_q, freq_word_d;
  logic [7:0]        retry_q, retry_d;
  logic              cfo_en_q, fine_en_q, freq_load_q, loop_rst_q, sync_hit_q, locked_q;
  logic              freq_load_d, loop_rst_d, sync_hit_d;

  logic [SYNC_W-1:0] win;
  logic [PW-1:0]     pop;
  logic              full, hit, restart;

  always_comb begin
    win = {sr_q, data_i};
    pop = '0;
    for (int i = 0; i < SYNC_W; i++) pop = pop + {{(PW-1){1'b0}}, win[i] ^ SYNC_WORD[i]};
    full = (state_q == S_LOCKED) || (cnt_q >= CW'(SYNC_W - 1));
    hit  = data_val_i && full && (int'(pop) <= TOL_LIM) &&
           ((state_q == S_SRCH) || (state_q == S_LOCKED));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    sr_d        = sr_q;
    freq_word_d = freq_word_q;
    retry_d     = retry_q;
    freq_load_d = 1'b0;
    loop_rst_d  = 1'b0;
    sync_hit_d  = 1'b0;
    restart     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_TIM_ACQ;
      S_TIM_ACQ: if (sym_val_i) begin
        if (cnt_q == CW'(SYM_SETTLE - 1)) state_d = S_CFO_CRS;
        else cnt_d = cnt_q + CW'(1);
      end
      S_CFO_CRS: begin
        if (coarse_done_i) begin
          freq_word_d = coarse_freq_i;
          freq_load_d = 1'b1;
          state_d     = S_CFO_TRK;
        end else if (sym_val_i) begin
          if (cnt_q == CW'(CFO_TIMEOUT - 1)) restart = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_CFO_TRK: if (sym_val_i) begin
        if (cnt_q == CW'(TRK_SETTLE - 1)) state_d = S_SRCH;
        else cnt_d = cnt_q + CW'(1);
      end
      S_SRCH: if (data_val_i) begin
        sr_d = win[SYNC_W-2:0];
        if (hit) begin
          sync_hit_d = 1'b1;
          state_d    = S_LOCKED;
        end else if (cnt_q == CW'(SRCH_TIMEOUT - 1)) restart = 1'b1;
        else cnt_d = cnt_q + CW'(1);
      end
      S_LOCKED: if (data_val_i) begin
        sr_d = win[SYNC_W-2:0];
        if (hit) begin
          sync_hit_d = 1'b1;
          cnt_d      = '0;
          miss_d     = '0;
        end else if (cnt_q == CW'(FRAME_BITS + SYNC_W - 1)) begin
          cnt_d = '0;
          if (miss_q == MW'(MISS_MAX - 1)) restart = 1'b1;
          else miss_d = miss_q + MW'(1);
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d    = S_TIM_ACQ;
      loop_rst_d = 1'b1;
      if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
    end

    // Dropping start overrides everything, including a same-cycle done or hit.
    if (!start_i) begin
      state_d     = S_IDLE;
      loop_rst_d  = (state_q != S_IDLE);
      freq_load_d = 1'b0;
      sync_hit_d  = 1'b0;
      freq_word_d = freq_word_q;
      retry_d     = retry_q;
    end

    if (state_d != state_q) begin
      cnt_d  = '0;
      miss_d = '0;
      if (state_d == S_SRCH) sr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      miss_q      <= '0;
      sr_q        <= '0;
      freq_word_q <= '0;
      retry_q     <= '0;
      cfo_en_q    <= 1'b0;
      fine_en_q   <= 1'b0;
      freq_load_q <= 1'b0;
      loop_rst_q  <= 1'b0;
      sync_hit_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      sr_q        <= sr_d;
      freq_word_q <= freq_word_d;
      retry_q     <= retry_d;
      cfo_en_q    <= (state_d == S_CFO_CRS);
      fine_en_q   <= (state_d == S_CFO_TRK) || (state_d == S_SRCH);
      freq_load_q <= freq_load_d;
      loop_rst_q  <= loop_rst_d;
      sync_hit_q  <= sync_hit_d;
      locked_q    <= (state_d == S_LOCKED);
    end
  end

  assign cfo_en_o    = cfo_en_q;
  assign fine_en_o   = fine_en_q;
  assign freq_load_o = freq_load_q;
  assign freq_word_o = freq_word_q;
  assign loop_rst_o  = loop_rst_q;
  assign sync_hit_o  = sync_hit_q;
  assign locked_o    = locked_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Directed-sequence bench for msk_rx_acq_ctrl with randomized strobe spacing and data, and a sliding-window sync model.
module tb_msk_rx_acq_ctrl;
  localparam int SYM_SETTLE   = 256;
  localparam int CFO_TIMEOUT  = 4096;
  localparam int TRK_SETTLE   = 512;
  localparam int SRCH_TIMEOUT = 8192;
  localparam int FRAME_BITS   = 256;
  localparam int MISS_MAX     = 3;
  localparam int SYNC_W       = 32;
  localparam logic [31:0] SYNC_WORD = 32'hFFA50FFE;
`ifdef MSK_ACQ_SYNC_TOL_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, sym_val_i = 1'b0, coarse_done_i = 1'b0;
  logic [31:0] coarse_freq_i = '0;
  logic        data_i = 1'b0, data_val_i = 1'b0;
  logic        cfo_en_o, fine_en_o, freq_load_o, loop_rst_o, sync_hit_o, locked_o;
  logic [31:0] freq_word_o;
  logic [2:0]  state_o;
  logic [7:0]  retry_cnt_o;

  msk_rx_acq_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sym_val_i(sym_val_i),
    .coarse_done_i(coarse_done_i), .coarse_freq_i(coarse_freq_i),
    .data_i(data_i), .data_val_i(data_val_i),
    .cfo_en_o(cfo_en_o), .fine_en_o(fine_en_o), .freq_load_o(freq_load_o),
    .freq_word_o(freq_word_o), .loop_rst_o(loop_rst_o), .sync_hit_o(sync_hit_o),
    .locked_o(locked_o), .state_o(state_o), .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_lrst = 0, n_load = 0;
  bit win[$];

  always @(negedge clk) if (!rst) begin
    if (loop_rst_o)  n_lrst++;
    if (freq_load_o) n_load++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      sym_val_i = 1'b1;
      step();
      sym_val_i = 1'b0;
    end
  endtask

  // Would appending bit b complete a window within TOL of the sync word?
  function automatic bit hit_with(input bit b);
    logic [31:0] w;
    w = '0;
    if (win.size() < SYNC_W - 1) return 1'b0;
    for (int i = 0; i < SYNC_W - 1; i++) w = {w[30:0], win[win.size() - (SYNC_W - 1) + i]};
    w = {w[30:0], b};
    return $countones(w ^ SYNC_WORD) <= TOL;
  endfunction

  task automatic send_bit(input bit b, input string tag);
    bit exp;
    exp = hit_with(b);
    win.push_back(b);
    if (win.size() > SYNC_W) void'(win.pop_front());
    repeat ($urandom_range(0, 1)) step();
    data_i = b; data_val_i = 1'b1;
    step();
    data_val_i = 1'b0; data_i = 1'($urandom);
    chk(tag, sync_hit_o, exp);
  endtask

  task automatic filler(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom);
      if (hit_with(b)) b = ~b;
      send_bit(b, "hit_fill");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i], "hit_sync");
  endtask

  // From TIM_ACQ, run a full acquisition and lock on a clean sync word.
  task automatic acquire_lock();
    logic [31:0] f;
    strobes(SYM_SETTLE);
    chk("acq_crs", state_o, 3'd2);
    strobes(5);
    f = $urandom;
    coarse_done_i = 1'b1; coarse_freq_i = f;
    step();
    coarse_done_i = 1'b0;
    chk("acq_trk", state_o, 3'd3);
    chk("acq_fword", freq_word_o, f);
    strobes(TRK_SETTLE);
    chk("acq_srch", state_o, 3'd4);
    win.delete();
    filler(40);
    send_word(SYNC_WORD);
    chk("acq_lock", state_o, 3'd5);
  endtask

  initial begin
    logic [7:0] r;
    // Reset values
    step(); step();
    chk("rst_state", state_o, 3'd0);
    chk("rst_en", {cfo_en_o, fine_en_o, locked_o, loop_rst_o, freq_load_o, sync_hit_o}, 6'd0);
    chk("rst_retry", retry_cnt_o, 8'd0);
    chk("rst_fword", freq_word_o, 32'd0);

    // Nominal acquisition
    rst = 1'b0; step();
    chk("idle_hold", state_o, 3'd0);
    start_i = 1'b1; step();
    chk("tim_enter", state_o, 3'd1);
    strobes(SYM_SETTLE - 1);
    chk("tim_last", {state_o, cfo_en_o}, {3'd1, 1'b0});
    strobes(1);
    chk("crs_enter", {state_o, cfo_en_o, fine_en_o}, {3'd2, 1'b1, 1'b0});
    strobes(100);
    chk("crs_wait", state_o, 3'd2);
    coarse_done_i = 1'b1; coarse_freq_i = 32'h0012_3456;
    step();
    coarse_done_i = 1'b0; coarse_freq_i = 32'hDEAD_BEEF;
    chk("trk_enter", {state_o, cfo_en_o, fine_en_o}, {3'd3, 1'b0, 1'b1});
    chk("load_pulse", {freq_load_o, freq_word_o}, {1'b1, 32'h0012_3456});
    step();
    chk("load_single", freq_load_o, 1'b0);
    coarse_done_i = 1'b1; step(); coarse_done_i = 1'b0;
    chk("done_ignored", {freq_load_o, freq_word_o}, {1'b0, 32'h0012_3456});
    strobes(TRK_SETTLE - 1);
    chk("trk_last", state_o, 3'd3);
    strobes(1);
    chk("srch_enter", {state_o, fine_en_o, locked_o}, {3'd4, 1'b1, 1'b0});
    win.delete();
    filler(50);
    send_word(SYNC_WORD);
    chk("lock_rise", {state_o, locked_o, sync_hit_o, fine_en_o}, {3'd5, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 2; k++) begin
      filler(FRAME_BITS - SYNC_W);
      send_word(SYNC_WORD);
      chk("frame_lock", {locked_o, sync_hit_o}, 2'b11);
    end
    chk("nom_loads", n_load, 1);
    chk("nom_lrst", n_lrst, 0);

    // Sync removed: MISS_MAX frames of (FRAME_BITS+SYNC_W) bits
    filler((FRAME_BITS + SYNC_W) * MISS_MAX - 1);
    chk("loss_hold", {state_o, locked_o}, {3'd5, 1'b1});
    filler(1);
    chk("loss_restart", {state_o, locked_o, loop_rst_o, retry_cnt_o}, {3'd1, 1'b0, 1'b1, 8'd1});

    // CFO timeout
    strobes(SYM_SETTLE);
    chk("to_crs", state_o, 3'd2);
    strobes(CFO_TIMEOUT - 1);
    chk("to_hold", {state_o, loop_rst_o}, {3'd2, 1'b0});
    strobes(1);
    chk("to_restart", {state_o, cfo_en_o, loop_rst_o, retry_cnt_o}, {3'd1, 1'b0, 1'b1, 8'd2});

    // Done coincident with the timeout strobe
    strobes(SYM_SETTLE);
    strobes(CFO_TIMEOUT - 1);
    sym_val_i = 1'b1; coarse_done_i = 1'b1; coarse_freq_i = 32'hA5A5_0001;
    step();
    sym_val_i = 1'b0; coarse_done_i = 1'b0;
    chk("done_wins", {state_o, loop_rst_o, retry_cnt_o}, {3'd3, 1'b0, 8'd2});
    chk("done_word", {freq_load_o, freq_word_o}, {1'b1, 32'hA5A5_0001});
    strobes(TRK_SETTLE);
    chk("err_srch", state_o, 3'd4);

    // Sync word with two bit errors
    win.delete();
    filler(40);
    send_word(SYNC_WORD ^ 32'h0001_0100);
`ifdef MSK_ACQ_SYNC_TOL_EN
    chk("err_lock", {state_o, locked_o}, {3'd5, 1'b1});
    r = 8'd2;
`else
    chk("err_nolock", state_o, 3'd4);
    filler(SRCH_TIMEOUT - 72 - 1);
    chk("srch_hold", state_o, 3'd4);
    filler(1);
    chk("srch_timeout", {state_o, loop_rst_o, retry_cnt_o}, {3'd1, 1'b1, 8'd3});
    acquire_lock();
    r = 8'd3;
`endif

    // start_i dropped while locked
    n_lrst = 0;
    start_i = 1'b0; step();
    chk("drop_idle", {state_o, cfo_en_o, fine_en_o, locked_o}, {3'd0, 3'd0});
    chk("drop_lrst", {loop_rst_o, retry_cnt_o}, {1'b1, r});
    step(); step();
    chk("drop_single", n_lrst, 1);

    // Same situation, but reset instead
    start_i = 1'b1; step();
    chk("re_tim", state_o, 3'd1);
    acquire_lock();
    n_lrst = 0;
    rst = 1'b1; start_i = 1'b0; step();
    chk("rst_mid", {state_o, locked_o, loop_rst_o, retry_cnt_o}, {3'd0, 1'b0, 1'b0, 8'd0});
    chk("rst_mid_word", freq_word_o, 32'd0);
    rst = 1'b0; step(); step();
    chk("rst_no_lrst", n_lrst, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/msk_rx_acq_ctrl.md
# msk_rx_acq_ctrl

Acquisition and lock sequencer for the MSK receive chain. It sits beside the timing-recovery loop, the coarse CFO estimator and the fine carrier loop, and steps them through timing settle, coarse CFO, fine tracking, sync-word search and lock. It enables each stage in turn and loads the coarse frequency word into the fine loop. It declares lock, detects loss of lock and restarts acquisition.

## Interface
- `SYM_SETTLE`, 256: symbol strobes to wait in timing acquisition before enabling CFO.
- `CFO_TIMEOUT`, 4096: symbol strobes allowed for a coarse CFO estimate.
- `TRK_SETTLE`, 512: symbol strobes of fine tracking before sync search starts.
- `FW`, 32: frequency word width.
- `SYNC_W`, 32: sync word length in bits.
- `SYNC_WORD`, 32'hFFA50FFE: sync pattern; MSB is received first.
- `SYNC_TOL`, 2: maximum Hamming distance accepted (used only with the macro).
- `SRCH_TIMEOUT`, 8192: data bits allowed in search without a sync hit.
- `FRAME_BITS`, 256: expected sync repetition period in bits.
- `MISS_MAX`, 3: consecutive missed frames that declare loss of lock.

Ports:
- `clk` in, 1: sole clock.
- `rst` in, 1: synchronous, active-high reset.
- `start_i` in, 1: level; acquisition runs while high.
- `sym_val_i` in, 1: one-cycle symbol strobe from the timing loop.
- `coarse_done_i` in, 1: one-cycle pulse, coarse estimate valid.
- `coarse_freq_i` in, FW: coarse frequency word, valid with `coarse_done_i`.
- `data_i` in, 1: sliced bit.
- `data_val_i` in, 1: strobe for `data_i`.
- `cfo_en_o` out, 1: coarse CFO estimator enable.
- `fine_en_o` out, 1: fine carrier loop and derotator enable.
- `freq_load_o` out, 1: one-cycle pulse; loads `freq_word_o` into the fine loop integrator.
- `freq_word_o` out, FW: latched coarse word.
- `loop_rst_o` out, 1: one-cycle pulse that clears the fine loop state.
- `sync_hit_o` out, 1: one-cycle pulse on a sync match.
- `locked_o` out, 1: lock indicator.
- `state_o` out, 3: current state code.
- `retry_cnt_o` out, 8: number of acquisition restarts; saturates at 255.

## Operation
- The state codes are IDLE=0, TIM_ACQ=1, CFO_CRS=2, CFO_TRK=3, SRCH=4, LOCKED=5.
- A single counter `cnt` counts symbol strobes in states 1–3 and data bits in states 4–5. It clears on every state entry.
- IDLE: all enables are low. When `start_i`=1, go to TIM_ACQ.
- TIM_ACQ: count `sym_val_i`. When `cnt`=SYM_SETTLE-1 and a strobe arrives, go to CFO_CRS.
- CFO_CRS:
  - `cfo_en_o`=1.
  - On `coarse_done_i`, latch `coarse_freq_i` into `freq_word_o`, pulse `freq_load_o` and go to CFO_TRK.
  - If CFO_TIMEOUT strobes pass without a done pulse, restart.
- CFO_TRK: `fine_en_o`=1. After TRK_SETTLE strobes, go to SRCH.
- SRCH:
  - `fine_en_o`=1.
  - A SYNC_W-bit shift register is cleared on entry. It shifts `data_i` in on each `data_val_i`.
  - A hit requires a full register, i.e. at least SYNC_W bits shifted since entry.
  - On a hit, go to LOCKED.
  - After SRCH_TIMEOUT bits without a hit, restart.
- LOCKED:
  - `locked_o`=1.
  - `cnt` counts bits since the last hit; a hit clears `cnt` and the miss counter.
  - When `cnt` reaches FRAME_BITS+SYNC_W without a hit, the miss counter increments and `cnt` clears.
  - When the miss counter reaches MISS_MAX, restart.
- Restart means: pulse `loop_rst_o`, increment `retry_cnt_o` (saturating), go to TIM_ACQ. `freq_word_o` is held.
- Precedence rules:
  - `start_i`=0 in any state sends the block to IDLE on the next cycle and pulses `loop_rst_o` if the block was not already in IDLE.
  - `coarse_done_i` in the same cycle as the CFO timeout: done wins.
  - A hit in the same cycle as the search timeout or the final miss: the hit wins.
  - `coarse_done_i` outside CFO_CRS is ignored.

## Timing
- Reset values: all outputs are 0, `state_o`=0, counters are 0.
- All outputs are registered. A state change is visible on `state_o` the cycle after the triggering input.
- Enables follow the state with the same one-cycle latency.
- `freq_load_o` and `freq_word_o` update in the same cycle, one cycle after `coarse_done_i`.
- `sync_hit_o` asserts one cycle after the `data_val_i` that completes the match.
- `locked_o` asserts in the same cycle as the first `sync_hit_o`.
- A reset mid-operation returns everything to reset values on the next edge and does not pulse `loop_rst_o`.

## Configuration
- `MSK_ACQ_SYNC_TOL_EN` defined: a hit is declared when the popcount of (shift register XOR SYNC_WORD) is ≤ SYNC_TOL.
- Not defined: exact match only, and SYNC_TOL is ignored.

## Test plan
- Nominal acquisition: start_i=1 with a strobe every 20 cycles; coarse_done_i with freq 32'h0012_3456 after 100 strobes; data stream carrying SYNC_WORD every 256 bits → states go 1→2→3→4→5. freq_load_o is a single pulse with freq_word_o=32'h0012_3456. locked_o rises in the same cycle as sync_hit_o.
- No coarse_done_i → after 4096 strobes in CFO_CRS: loop_rst_o pulses, retry_cnt_o=1, state=1.
- Lock then sync removed → after 3×288 bits: locked_o falls, loop_rst_o pulses, state=1.
- Sync with 2 bit errors → lock only when built with MSK_ACQ_SYNC_TOL_EN; without the macro, retry after 8192 bits.
- start_i dropped in LOCKED → next cycle state=0, all enables 0, one loop_rst_o pulse. Same stimulus with rst=1 → no loop_rst_o pulse and retry_cnt_o=0.
- coarse_done_i in the same cycle as strobe 4096 → done wins: state=3 and retry_cnt_o unchanged.
